// File: rtl/clock_set_controller.sv
// Mode-driven set controller for a clock display: selects the field being set, issues
// increment/clear pulses from the button, and blinks the field. Auto-repeat: CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_controller #(
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int BLINK_TICKS  = 250
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_ms_i,
    input  logic       initial_mode_i,
    input  logic       mode1_i,
    input  logic       mode2_i,
    input  logic       mode3_i,
    input  logic       inc_button_i,
    output logic       run_en_o,
    output logic       inc_hour_o,
    output logic       inc_min_o,
    output logic       clr_sec_o,
    output logic [1:0] field_sel_o,
    output logic       blink_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    if (HOLD_TICKS < 1 || REPEAT_TICKS < 1 || BLINK_TICKS < 2) begin : g_param_check
        $error("clock_set_controller: tick parameters out of range");
    end

    state_t          state;
    state_t          next_state;
    logic            btn_q;
    logic            btn_edge;
    logic            state_chg;
    logic            in_set;
    logic            fire;
    logic [BW-1:0]   blink_cnt;

    logic            run_en_d;
    logic [1:0]      field_sel_d;
    logic            inc_hour_d;
    logic            inc_min_d;
    logic            clr_sec_d;

    // ---------------- state register ----------------
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: next_state gets a default before the case so no latch can be inferred.
    always_comb begin
        next_state = RUN;
        case ({initial_mode_i, mode1_i, mode2_i, mode3_i})
            4'b1000: next_state = RUN;
            4'b0100: next_state = SET_HOUR;
            4'b0010: next_state = SET_MIN;
            4'b0001: next_state = SET_SEC;
            default: next_state = RUN;
        endcase
    end

    assign btn_edge  = inc_button_i & ~btn_q;
    assign state_chg = (next_state != state);
    assign in_set    = (state != RUN);

    // NOTE: button history resets to 1 so a level held through reset never looks like a press.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= inc_button_i;
        end
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic          armed;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          repeat_fire;

    // armed marks a press accepted in the current SET state; only such a press may repeat
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (state_chg || !inc_button_i) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (btn_edge) begin
            armed    <= in_set;
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (tick_ms_i && armed) begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        repeat_fire = 1'b0;
        if (armed && inc_button_i && tick_ms_i && !btn_edge && !state_chg) begin
            repeat_fire = (hold_cnt == HOLD_MAX) ? (rep_cnt == REP_LAST)
                                                 : (hold_cnt == HOLD_PRE);
        end
    end

    assign fire = (btn_edge && !state_chg && in_set) || repeat_fire;
`else
    assign fire = btn_edge && !state_chg && in_set;
`endif

    // blink restarts visible on every state change and is held off in RUN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            blink_cnt <= '0;
            blink_o   <= 1'b0;
        end else if (state_chg || !in_set) begin
            blink_cnt <= '0;
            blink_o   <= 1'b0;
        end else if (tick_ms_i) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_o   <= ~blink_o;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        run_en_d    = (state == RUN);
        field_sel_d = state;
        inc_hour_d  = fire && (state == SET_HOUR);
        inc_min_d   = fire && (state == SET_MIN);
        clr_sec_d   = fire && (state == SET_SEC);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            run_en_o    <= 1'b1;
            field_sel_o <= 2'b00;
            inc_hour_o  <= 1'b0;
            inc_min_o   <= 1'b0;
            clr_sec_o   <= 1'b0;
        end else begin
            run_en_o    <= run_en_d;
            field_sel_o <= field_sel_d;
            inc_hour_o  <= inc_hour_d;
            inc_min_o   <= inc_min_d;
            clr_sec_o   <= clr_sec_d;
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small tick parameters and a 1-in-4 tick strobe.
module tb_clock_set_controller;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       tick_ms_i = 1'b0;
    logic       initial_mode_i;
    logic       mode1_i;
    logic       mode2_i;
    logic       mode3_i;
    logic       inc_button_i;
    logic       run_en_o;
    logic       inc_hour_o;
    logic       inc_min_o;
    logic       clr_sec_o;
    logic [1:0] field_sel_o;
    logic       blink_o;

    int vec_n = 0;
    int err_n = 0;
    int hour_n = 0;
    int min_n = 0;
    int sec_n = 0;
    int multi_n = 0;
    int run_pulse_n = 0;

    clock_set_controller #(
        .HOLD_TICKS  (5),
        .REPEAT_TICKS(2),
        .BLINK_TICKS (3)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .tick_ms_i     (tick_ms_i),
        .initial_mode_i(initial_mode_i),
        .mode1_i       (mode1_i),
        .mode2_i       (mode2_i),
        .mode3_i       (mode3_i),
        .inc_button_i  (inc_button_i),
        .run_en_o      (run_en_o),
        .inc_hour_o    (inc_hour_o),
        .inc_min_o     (inc_min_o),
        .clr_sec_o     (clr_sec_o),
        .field_sel_o   (field_sel_o),
        .blink_o       (blink_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk_i);
            #1;
            tick_ms_i = (c == 3);
            c = (c + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (inc_hour_o === 1'b1) hour_n++;
            if (inc_min_o === 1'b1)  min_n++;
            if (clr_sec_o === 1'b1)  sec_n++;
            if ((int'(inc_hour_o) + int'(inc_min_o) + int'(clr_sec_o)) > 1) multi_n++;
            if (run_en_o && (inc_hour_o || inc_min_o || clr_sec_o)) run_pulse_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_mode(input logic [3:0] m);
        {initial_mode_i, mode1_i, mode2_i, mode3_i} = m;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk_i);
            if (tick_ms_i) k++;
        end
    endtask

    task automatic clear_counts();
        hour_n = 0;
        min_n  = 0;
        sec_n  = 0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        inc_button_i = 1'b0;
        set_mode(4'b1000);
        idle(3);
        vec_n++; if (run_en_o !== 1'b1) begin err_n++; $display("FAIL por_run_en: got %0b expected 1", run_en_o); end
        vec_n++; if (field_sel_o !== 2'b00) begin err_n++; $display("FAIL por_field_sel: got %0b expected 00", field_sel_o); end
        vec_n++; if (blink_o !== 1'b0) begin err_n++; $display("FAIL por_blink: got %0b expected 0", blink_o); end
        reset_i = 1'b0;
        set_mode(4'b0100);
        idle(3);
        vec_n++; if (field_sel_o !== 2'b01) begin err_n++; $display("FAIL sethour_field_sel: got %0b expected 01", field_sel_o); end
        vec_n++; if (run_en_o !== 1'b0) begin err_n++; $display("FAIL sethour_run_en: got %0b expected 0", run_en_o); end
        // reset mid-cycle with the button going high at the same instant
        #2;
        reset_i = 1'b1;
        inc_button_i = 1'b1;
        #1;
        vec_n++; if (run_en_o !== 1'b1) begin err_n++; $display("FAIL async_run_en: got %0b expected 1", run_en_o); end
        vec_n++; if (field_sel_o !== 2'b00) begin err_n++; $display("FAIL async_field_sel: got %0b expected 00", field_sel_o); end
        vec_n++; if (blink_o !== 1'b0) begin err_n++; $display("FAIL async_blink: got %0b expected 0", blink_o); end
        vec_n++; if ({inc_hour_o, inc_min_o, clr_sec_o} !== 3'b000) begin err_n++; $display("FAIL async_pulses: got %0b expected 000", {inc_hour_o, inc_min_o, clr_sec_o}); end
        idle(2);
        reset_i = 1'b0;
        clear_counts();
        idle(4);
        vec_n++; if (hour_n !== 0) begin err_n++; $display("FAIL held_through_reset: got %0d pulses expected 0", hour_n); end
        vec_n++; if (field_sel_o !== 2'b01) begin err_n++; $display("FAIL post_reset_field_sel: got %0b expected 01", field_sel_o); end
        inc_button_i = 1'b0;
        idle(2);
    endtask

    task automatic test_single_press();
        set_mode(4'b0010);
        idle(3);
        vec_n++; if (field_sel_o !== 2'b10) begin err_n++; $display("FAIL setmin_field_sel: got %0b expected 10", field_sel_o); end
        vec_n++; if (run_en_o !== 1'b0) begin err_n++; $display("FAIL setmin_run_en: got %0b expected 0", run_en_o); end
        clear_counts();
        inc_button_i = 1'b1;
        @(posedge clk_i); #1;
        vec_n++; if (inc_min_o !== 1'b1) begin err_n++; $display("FAIL single_pulse_high: got %0b expected 1", inc_min_o); end
        @(posedge clk_i); #1;
        vec_n++; if (inc_min_o !== 1'b0) begin err_n++; $display("FAIL single_pulse_low: got %0b expected 0", inc_min_o); end
        wait_ticks(2);
        @(negedge clk_i);
        inc_button_i = 1'b0;
        idle(3);
        vec_n++; if (min_n !== 1) begin err_n++; $display("FAIL single_min_count: got %0d expected 1", min_n); end
        vec_n++; if (hour_n + sec_n !== 0) begin err_n++; $display("FAIL single_other_count: got %0d expected 0", hour_n + sec_n); end
    endtask

    task automatic test_auto_repeat();
        int exp_n;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        set_mode(4'b0100);
        idle(3);
        clear_counts();
        inc_button_i = 1'b1;
        @(posedge clk_i);
        wait_ticks(12);
        @(negedge clk_i);
        inc_button_i = 1'b0;
        idle(3);
        vec_n++; if (hour_n !== exp_n) begin err_n++; $display("FAIL repeat_hour_count: got %0d expected %0d", hour_n, exp_n); end
        vec_n++; if (min_n + sec_n !== 0) begin err_n++; $display("FAIL repeat_other_count: got %0d expected 0", min_n + sec_n); end
    endtask

    task automatic test_mode_change_held();
        set_mode(4'b0001);
        idle(3);
        clear_counts();
        inc_button_i = 1'b1;
        @(posedge clk_i);
        wait_ticks(2);
        @(negedge clk_i);
        set_mode(4'b0100);
        wait_ticks(8);
        @(negedge clk_i);
        vec_n++; if (hour_n !== 0) begin err_n++; $display("FAIL held_change_hour: got %0d expected 0", hour_n); end
        vec_n++; if (sec_n !== 1) begin err_n++; $display("FAIL held_change_sec: got %0d expected 1", sec_n); end
        vec_n++; if (field_sel_o !== 2'b01) begin err_n++; $display("FAIL held_change_field: got %0b expected 01", field_sel_o); end
        inc_button_i = 1'b0;
        idle(2);
        inc_button_i = 1'b1;
        idle(2);
        inc_button_i = 1'b0;
        idle(2);
        vec_n++; if (hour_n !== 1) begin err_n++; $display("FAIL repress_hour: got %0d expected 1", hour_n); end
    endtask

    task automatic test_coincident();
        set_mode(4'b0010);
        idle(3);
        clear_counts();
        set_mode(4'b0100);
        inc_button_i = 1'b1;
        idle(4);
        vec_n++; if (hour_n + min_n + sec_n !== 0) begin err_n++; $display("FAIL coincident_pulses: got %0d expected 0", hour_n + min_n + sec_n); end
        vec_n++; if (field_sel_o !== 2'b01) begin err_n++; $display("FAIL coincident_field: got %0b expected 01", field_sel_o); end
        inc_button_i = 1'b0;
        idle(2);
    endtask

    task automatic test_illegal_mode();
        set_mode(4'b0110);
        idle(3);
        vec_n++; if (field_sel_o !== 2'b00) begin err_n++; $display("FAIL illegal_field: got %0b expected 00", field_sel_o); end
        vec_n++; if (run_en_o !== 1'b1) begin err_n++; $display("FAIL illegal_run_en: got %0b expected 1", run_en_o); end
        clear_counts();
        inc_button_i = 1'b1;
        idle(3);
        inc_button_i = 1'b0;
        idle(2);
        vec_n++; if (hour_n + min_n + sec_n !== 0) begin err_n++; $display("FAIL illegal_pulses: got %0d expected 0", hour_n + min_n + sec_n); end
        set_mode(4'b0000);
        idle(3);
        vec_n++; if (field_sel_o !== 2'b00) begin err_n++; $display("FAIL nomode_field: got %0b expected 00", field_sel_o); end
    endtask

    task automatic test_blink();
        logic exp_b;
        set_mode(4'b1000);
        idle(3);
        vec_n++; if (blink_o !== 1'b0) begin err_n++; $display("FAIL blink_run: got %0b expected 0", blink_o); end
        set_mode(4'b0001);
        @(posedge clk_i); #1;
        vec_n++; if (blink_o !== 1'b0) begin err_n++; $display("FAIL blink_entry: got %0b expected 0", blink_o); end
        for (int k = 1; k <= 12; k++) begin
            wait_ticks(1);
            #1;
            exp_b = ((k / 3) % 2) == 1;
            vec_n++; if (blink_o !== exp_b) begin err_n++; $display("FAIL blink_tick%0d: got %0b expected %0b", k, blink_o, exp_b); end
        end
        wait_ticks(3);
        #1;
        vec_n++; if (blink_o !== 1'b1) begin err_n++; $display("FAIL blink_tick15: got %0b expected 1", blink_o); end
        @(negedge clk_i);
        set_mode(4'b1000);
        @(posedge clk_i); #1;
        vec_n++; if (blink_o !== 1'b0) begin err_n++; $display("FAIL blink_exit: got %0b expected 0", blink_o); end
        idle(2);
        vec_n++; if (field_sel_o !== 2'b00) begin err_n++; $display("FAIL blink_exit_field: got %0b expected 00", field_sel_o); end
        vec_n++; if (run_en_o !== 1'b1) begin err_n++; $display("FAIL blink_exit_run_en: got %0b expected 1", run_en_o); end
    endtask

    task automatic test_exclusive();
        vec_n++; if (multi_n !== 0) begin err_n++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", multi_n); end
        vec_n++; if (run_pulse_n !== 0) begin err_n++; $display("FAIL pulse_in_run: got %0d expected 0", run_pulse_n); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_mode_change_held();
        test_coincident();
        test_illegal_mode();
        test_blink();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
